cs_frame_arbiter: RTL and testbench

CS_FRAME_ARBITER -- requirements
Module: cs_frame_arbiter

---
 rtl/cs_frame_arbiter_if.sv | 29 ++
 rtl/cs_frame_arbiter.sv | 166 ++++++++++++++++
 tb/tb_cs_frame_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cs_frame_arbiter_if.sv
// Bundle of requester-side and shared-stream signals for the frame arbiter.
// The arbiter connects through the slave modport; the requester/sink side uses master.
interface cs_frame_arbiter_if #(
    parameter int N_SRC = 4
);
    logic [N_SRC-1:0]    s_req;
    logic [N_SRC-1:0]    s_gnt;
    logic [32*N_SRC-1:0] s_cs_addr;
    logic [32*N_SRC-1:0] s_cs_data;
    logic [N_SRC-1:0]    s_cs_valid;
    logic [N_SRC-1:0]    s_cs_last;
    logic [31:0]         m_cs_addr;
    logic [31:0]         m_cs_data;
    logic                m_cs_fs;
    logic                m_cs_user;
    logic                busy;
    logic [2:0]          owner;
    logic                err;

    modport master (
        output s_req, s_cs_addr, s_cs_data, s_cs_valid, s_cs_last,
        input  s_gnt, m_cs_addr, m_cs_data, m_cs_fs, m_cs_user, busy, owner, err
    );

    modport slave (
        input  s_req, s_cs_addr, s_cs_data, s_cs_valid, s_cs_last,
        output s_gnt, m_cs_addr, m_cs_data, m_cs_fs, m_cs_user, busy, owner, err
    );
endinterface

// File: rtl/cs_frame_arbiter.sv
// Round-robin frame arbiter: grants one requester at a time and forwards its
// words onto a shared registered stream, aborting frames on timeout or request loss.
module cs_frame_arbiter #(
    parameter int N_SRC   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    cs_frame_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, XFER} state_t;

    state_t             r_state;
    logic [N_SRC-1:0]   r_gnt;
    logic [2:0]         r_owner;
    logic [2:0]         r_rr_ptr;
    logic [15:0]        r_idle_cnt;
    logic               r_first;
    logic               r_busy;
    logic               r_err;
    logic               r_fs;
    logic               r_user;
    logic [31:0]        r_addr;
    logic [31:0]        r_data;

    logic [31:0]        w_addr_m [N_SRC];
    logic [31:0]        w_data_m [N_SRC];
    logic [31:0]        w_sel_addr;
    logic [31:0]        w_sel_data;
    logic               w_acc;
    logic               w_acc_last;
    logic               w_req_held;
    logic [15:0]        w_cnt_inc;
    logic               w_timeout;

    logic [2*N_SRC-1:0] w_req2;
    logic [3:0]         w_shamt;
    logic [N_SRC-1:0]   w_rot;
    logic [3:0]         w_off;
    logic [3:0]         w_sum;
    logic               w_found;
    logic [2:0]         w_win;

    // Grant is one-hot, so masking each slice by its grant bit and OR-ing gives the mux
    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_slice
            assign w_addr_m[gi] = {32{r_gnt[gi]}} & bus.s_cs_addr[32*gi +: 32];
            assign w_data_m[gi] = {32{r_gnt[gi]}} & bus.s_cs_data[32*gi +: 32];
        end
    endgenerate

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int k = 0; k < N_SRC; k++) begin
            w_sel_addr = w_sel_addr | w_addr_m[k];
            w_sel_data = w_sel_data | w_data_m[k];
        end
    end

    assign w_acc      = (r_state == XFER) && |(bus.s_cs_valid & r_gnt);
    assign w_acc_last = w_acc && |(bus.s_cs_last & r_gnt);
    assign w_req_held = |(bus.s_req & r_gnt);
    assign w_cnt_inc  = r_idle_cnt + 16'd1;
    assign w_timeout  = (w_cnt_inc == 16'(TIMEOUT));

    // Rotate requests so bit 0 is the requester just after rr_ptr
    assign w_req2  = {bus.s_req, bus.s_req};
    assign w_shamt = {1'b0, r_rr_ptr} + 4'd1;
    assign w_rot   = N_SRC'(w_req2 >> w_shamt);

    always_comb begin
        w_found = 1'b0;
        w_off   = 4'd0;
        for (int j = N_SRC - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_found = 1'b1;
                w_off   = 4'(j);
            end
        end
        w_sum = w_shamt + w_off;
        if (w_sum >= 4'(N_SRC)) begin
            w_sum = w_sum - 4'(N_SRC);
        end
        w_win = w_sum[2:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_owner    <= '0;
            r_rr_ptr   <= 3'(N_SRC - 1);
            r_idle_cnt <= '0;
            r_first    <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_fs       <= 1'b0;
            r_user     <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
        end else begin
            r_user <= 1'b0;
            r_fs   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state    <= XFER;
                        r_gnt      <= {{(N_SRC-1){1'b0}}, 1'b1} << w_win;
                        r_owner    <= w_win;
                        r_rr_ptr   <= w_win;
                        r_busy     <= 1'b1;
                        r_idle_cnt <= '0;
                        r_first    <= 1'b1;
                    end
                end
                XFER: begin
                    if (w_acc_last) begin
                        // A last word wins over request loss or timeout in the same cycle
                        r_user     <= 1'b1;
                        r_fs       <= r_first;
                        r_addr     <= w_sel_addr;
                        r_data     <= w_sel_data;
                        r_first    <= 1'b0;
                        r_state    <= IDLE;
                        r_gnt      <= '0;
                        r_owner    <= '0;
                        r_busy     <= 1'b0;
                        r_idle_cnt <= '0;
                    end else if (!w_req_held || (!w_acc && w_timeout)) begin
                        r_err      <= 1'b1;
                        r_state    <= IDLE;
                        r_gnt      <= '0;
                        r_owner    <= '0;
                        r_busy     <= 1'b0;
                        r_idle_cnt <= '0;
                        r_first    <= 1'b0;
                    end else if (w_acc) begin
                        r_user     <= 1'b1;
                        r_fs       <= r_first;
                        r_addr     <= w_sel_addr;
                        r_data     <= w_sel_data;
                        r_first    <= 1'b0;
                        r_idle_cnt <= '0;
                    end else begin
                        r_idle_cnt <= w_cnt_inc;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.s_gnt     = r_gnt;
    assign bus.owner     = r_owner;
    assign bus.busy      = r_busy;
    assign bus.err       = r_err;
    assign bus.m_cs_addr = r_addr;
    assign bus.m_cs_data = r_data;
    assign bus.m_cs_fs   = r_fs;
    assign bus.m_cs_user = r_user;
endmodule

// File: tb/tb_cs_frame_arbiter.sv
// Scoreboard bench for cs_frame_arbiter: stimulus pushes expected words and grants,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_cs_frame_arbiter;
    localparam int N  = 4;
    localparam int TO = 4;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        fs;
        int          c;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cs_frame_arbiter_if #(.N_SRC(N)) bus ();

    cs_frame_arbiter #(.N_SRC(N), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         err_cnt  = 0;
    int         exp_err  = 0;
    bit         mon_en   = 1'b0;
    word_t      exp_q[$];
    int         exp_gnt[$];
    logic [N-1:0] prev_gnt = '0;
    logic       prev_err = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: stream words, idle-zero rule, grant order/gap, err pulse width
    initial begin
        word_t e;
        int    eg;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                n_checks++;
                if (bus.m_cs_user) begin
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL word_unexpected: got addr=0x%08h data=0x%08h required none", bus.m_cs_addr, bus.m_cs_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.m_cs_addr !== e.a || bus.m_cs_data !== e.d || bus.m_cs_fs !== e.fs || cyc != e.c) begin
                            n_fail++;
                            $display("FAIL word: got addr=0x%08h data=0x%08h fs=%0b cyc=%0d required addr=0x%08h data=0x%08h fs=%0b cyc=%0d",
                                     bus.m_cs_addr, bus.m_cs_data, bus.m_cs_fs, cyc, e.a, e.d, e.fs, e.c);
                        end else begin
                            $display("word ok addr=0x%08h data=0x%08h fs=%0b cyc=%0d", e.a, e.d, e.fs, cyc);
                        end
                    end
                end else if (bus.m_cs_addr !== 32'd0 || bus.m_cs_data !== 32'd0 || bus.m_cs_fs !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_zero: got addr=0x%08h data=0x%08h fs=%0b required all 0", bus.m_cs_addr, bus.m_cs_data, bus.m_cs_fs);
                end
                if (bus.s_gnt != prev_gnt && bus.s_gnt != '0) begin
                    n_checks++;
                    if (prev_gnt != '0) begin
                        n_fail++;
                        $display("FAIL gnt_gap: got 0x%0h after 0x%0h required a zero cycle between", bus.s_gnt, prev_gnt);
                    end else if (exp_gnt.size() == 0) begin
                        n_fail++;
                        $display("FAIL gnt_unexpected: got owner=%0d required no grant", bus.owner);
                    end else begin
                        eg = exp_gnt.pop_front();
                        if (bus.owner !== 3'(eg) || bus.s_gnt !== (N'(1) << eg) || bus.busy !== 1'b1) begin
                            n_fail++;
                            $display("FAIL gnt: got owner=%0d gnt=0x%0h busy=%0b required owner=%0d gnt=0x%0h busy=1",
                                     bus.owner, bus.s_gnt, bus.busy, eg, N'(1) << eg);
                        end else begin
                            $display("grant ok owner=%0d cyc=%0d", eg, cyc);
                        end
                    end
                end
                if (bus.err) begin
                    n_checks++;
                    err_cnt++;
                    if (prev_err) begin
                        n_fail++;
                        $display("FAIL err_width: got err high 2 cycles required 1");
                    end
                end
                prev_gnt = bus.s_gnt;
                prev_err = bus.err;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end else begin
            $display("check ok %s = 0x%0h", name, act);
        end
    endtask

    task automatic wait_gnt(input int k);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.s_gnt[k]) break;
        end
        check("grant_wait", {31'd0, bus.s_gnt[k]}, 32'd1);
    endtask

    // Present one word for one cycle and expect it on the stream one cycle later
    task automatic send_word(input int idx, input logic [31:0] a, input logic [31:0] d,
                             input logic last, input logic fs);
        word_t w;
        bus.s_cs_addr[32*idx +: 32] = a;
        bus.s_cs_data[32*idx +: 32] = d;
        bus.s_cs_valid[idx]         = 1'b1;
        bus.s_cs_last[idx]          = last;
        w.a = a; w.d = d; w.fs = fs; w.c = cyc + 1;
        exp_q.push_back(w);
        tick();
        bus.s_cs_valid[idx] = 1'b0;
        bus.s_cs_last[idx]  = 1'b0;
    endtask

    initial begin
        int seq [5];
        int t0;
        seq = '{0, 1, 2, 3, 0};
        bus.s_req      = '0;
        bus.s_cs_addr  = '0;
        bus.s_cs_data  = '0;
        bus.s_cs_valid = '0;
        bus.s_cs_last  = '0;

        tick();
        tick();
        mon_en = 1'b1;
        check("rst_gnt",   {28'd0, bus.s_gnt}, 32'd0);
        check("rst_busy",  {31'd0, bus.busy}, 32'd0);
        check("rst_owner", {29'd0, bus.owner}, 32'd0);
        check("rst_user",  {31'd0, bus.m_cs_user}, 32'd0);
        check("rst_err",   {31'd0, bus.err}, 32'd0);
        rst = 1'b0;

        // Round robin over all-requesting, single-word frames
        for (int i = 0; i < 5; i++) exp_gnt.push_back(seq[i]);
        bus.s_req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_gnt(seq[i]);
            send_word(seq[i], 32'hA000_0000 + 32'(i), 32'hD000_0000 + 32'(i), 1'b1, 1'b1);
            if (i == 4) bus.s_req = '0;
        end

        // Requester 2, three-word frame
        exp_gnt.push_back(2);
        bus.s_req = 4'b0100;
        wait_gnt(2);
        send_word(2, 32'h0000_00A0, 32'h0000_00D0, 1'b0, 1'b1);
        send_word(2, 32'h0000_00A1, 32'h0000_00D1, 1'b0, 1'b0);
        send_word(2, 32'h0000_00A2, 32'h0000_00D2, 1'b1, 1'b0);
        bus.s_req = '0;
        check("f3_gnt_drop",  {28'd0, bus.s_gnt}, 32'd0);
        check("f3_busy_drop", {31'd0, bus.busy}, 32'd0);

        // Timeout: one word then stall
        exp_gnt.push_back(3);
        bus.s_req = 4'b1000;
        wait_gnt(3);
        send_word(3, 32'h3333_0000, 32'h3333_1111, 1'b0, 1'b1);
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.err) break;
        end
        bus.s_req = '0;
        exp_err++;
        check("to_delay",  32'(cyc - t0), 32'd4);
        check("to_err",    {31'd0, bus.err}, 32'd1);
        check("to_gnt",    {28'd0, bus.s_gnt}, 32'd0);
        check("to_busy",   {31'd0, bus.busy}, 32'd0);
        tick();
        check("to_err_end", {31'd0, bus.err}, 32'd0);

        // Non-granted requester 1 toggles valid during requester 0's frame
        exp_gnt.push_back(0);
        bus.s_req = 4'b0001;
        wait_gnt(0);
        bus.s_cs_addr[32 +: 32] = 32'hBAD0_0001;
        bus.s_cs_data[32 +: 32] = 32'hBAD0_D001;
        for (int j = 0; j < 5; j++) begin
            bus.s_cs_valid[1] = (j % 2 == 0);
            bus.s_cs_last[1]  = (j == 4);
            if (j % 2 == 0) send_word(0, 32'h0000_0F00 + 32'(j), 32'h0000_0E00 + 32'(j), j == 4, j == 0);
            else tick();
        end
        bus.s_req = '0;
        bus.s_cs_valid[1] = 1'b0;
        bus.s_cs_last[1]  = 1'b0;

        // Request dropped together with last word: normal completion
        exp_gnt.push_back(1);
        bus.s_req = 4'b0010;
        wait_gnt(1);
        send_word(1, 32'h1111_0000, 32'h1111_D000, 1'b0, 1'b1);
        bus.s_req[1] = 1'b0;
        send_word(1, 32'h1111_0001, 32'h1111_D001, 1'b1, 1'b0);
        check("drop_last_err", {31'd0, bus.err}, 32'd0);
        check("drop_last_gnt", {28'd0, bus.s_gnt}, 32'd0);

        // Request dropped one word early: abort, later words ignored
        exp_gnt.push_back(2);
        bus.s_req = 4'b0100;
        wait_gnt(2);
        send_word(2, 32'h2222_0000, 32'h2222_D000, 1'b0, 1'b1);
        bus.s_req[2] = 1'b0;
        tick();
        exp_err++;
        check("early_err", {31'd0, bus.err}, 32'd1);
        check("early_gnt", {28'd0, bus.s_gnt}, 32'd0);
        bus.s_cs_addr[64 +: 32] = 32'h2222_0001;
        bus.s_cs_data[64 +: 32] = 32'h2222_D001;
        bus.s_cs_valid[2] = 1'b1;
        bus.s_cs_last[2]  = 1'b1;
        tick();
        tick();
        bus.s_cs_valid[2] = 1'b0;
        bus.s_cs_last[2]  = 1'b0;

        // Reset during the second word of requester 1's frame
        exp_gnt.push_back(1);
        bus.s_req = 4'b0010;
        wait_gnt(1);
        send_word(1, 32'h4444_0000, 32'h4444_D000, 1'b0, 1'b1);
        bus.s_cs_addr[32 +: 32] = 32'h4444_0001;
        bus.s_cs_data[32 +: 32] = 32'h4444_D001;
        bus.s_cs_valid[1] = 1'b1;
        rst = 1'b1;
        tick();
        check("mrst_gnt",   {28'd0, bus.s_gnt}, 32'd0);
        check("mrst_busy",  {31'd0, bus.busy}, 32'd0);
        check("mrst_owner", {29'd0, bus.owner}, 32'd0);
        check("mrst_user",  {31'd0, bus.m_cs_user}, 32'd0);
        check("mrst_err",   {31'd0, bus.err}, 32'd0);
        rst = 1'b0;
        bus.s_cs_valid[1] = 1'b0;
        bus.s_req = '0;

        // After reset requester 0 wins with everyone requesting
        exp_gnt.push_back(0);
        bus.s_req = 4'b1111;
        wait_gnt(0);
        send_word(0, 32'h5555_0000, 32'h5555_D000, 1'b1, 1'b1);
        bus.s_req = '0;

        for (int i = 0; i < 4; i++) tick();
        check("words_left",  32'(exp_q.size()), 32'd0);
        check("grants_left", 32'(exp_gnt.size()), 32'd0);
        check("err_pulses",  32'(err_cnt), 32'(exp_err));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
